perceptron_sequencer: RTL

PERCEPTRON_SEQUENCER -- requirements
Module: perceptron_sequencer

---
 rtl/perceptron_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/perceptron_sequencer.sv
// Fixed-point perceptron: streams N w/x pairs plus a bias from BRAM, then writes the activated result back.
// Latency: start accepted at E0, done pulses after E(N+3); one BRAM write per run.
// No backpressure: start while busy is ignored, and the BRAM is assumed to return data one cycle after each address.
module perceptron_sequencer #(
    parameter int         N         = 8,
    parameter int         DW        = 16,
    parameter int         FRAC      = 8,
    parameter logic [8:0] BASE_ADDR = 9'd0,
    parameter logic [8:0] OUT_ADDR  = 9'd8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            act_mode,
    output logic            busy,
    output logic            done,
    output logic [8:0]      bram_addr,
    input  logic [2*DW-1:0] bram_rdata,
    output logic            bram_we,
    output logic [2*DW-1:0] bram_wdata,
    output logic [DW-1:0]   y,
    output logic            fire
);

    localparam int KW = $clog2(N + 1) + 1;
    localparam int AW = 2 * DW + $clog2(N + 1) + 1;
    localparam logic [KW-1:0] K_LAST = KW'(N);
    localparam logic signed [AW-1:0] Y_MAX = {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [AW-1:0] Y_MIN = {{(AW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [KW-1:0]        k;
    logic                 mode_lat;
    logic                 rd_vld;
    logic                 rd_last;
    logic signed [AW-1:0] acc;

    logic signed [DW-1:0]   w_s;
    logic signed [DW-1:0]   x_s;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW-1:0]   bias_sx;
    logic signed [AW-1:0]   bias_ext;
    logic signed [AW-1:0]   pre;
    logic [DW-1:0]          y_next;
    logic                   fire_next;

    assign w_s      = bram_rdata[2*DW-1:DW];
    assign x_s      = bram_rdata[DW-1:0];
    assign prod     = w_s * x_s;
    assign prod_ext = {{(AW - 2 * DW){prod[2*DW-1]}}, prod};
    // Bias is stored with FRAC fraction bits; align it to the 2*FRAC scale of the products.
    assign bias_sx  = {{(AW - DW){x_s[DW-1]}}, x_s};
    assign bias_ext = bias_sx <<< FRAC;
    assign pre      = acc >>> FRAC;

    always_comb begin
        fire_next = !pre[AW-1] && (|pre);
        if (mode_lat && pre[AW-1]) begin
            y_next = '0;
        end else if (pre > Y_MAX) begin
            y_next = Y_MAX[DW-1:0];
        end else if (pre < Y_MIN) begin
            y_next = Y_MIN[DW-1:0];
        end else begin
            y_next = pre[DW-1:0];
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_wdata = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                busy      = 1'b1;
                bram_addr = BASE_ADDR + 9'(k);
                if (k == K_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                bram_we    = 1'b1;
                bram_addr  = OUT_ADDR;
                bram_wdata = {{DW{1'b0}}, y_next};
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k        <= '0;
            mode_lat <= 1'b0;
            rd_vld   <= 1'b0;
            rd_last  <= 1'b0;
            acc      <= '0;
            done     <= 1'b0;
            y        <= '0;
            fire     <= 1'b0;
        end else begin
            done    <= (state == WRITE);
            // Data for the address presented in READ arrives one cycle later.
            rd_vld  <= (state == READ);
            rd_last <= (state == READ) && (k == K_LAST);
            if (rd_vld) begin
                acc <= acc + (rd_last ? bias_ext : prod_ext);
            end
            if (state == READ) begin
                k <= k + 1'b1;
            end
            if (state == IDLE && start) begin
                k        <= '0;
                mode_lat <= act_mode;
                acc      <= '0;
            end
            if (state == WRITE) begin
                y    <= y_next;
                fire <= fire_next;
            end
        end
    end

endmodule
